// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the rPLL lock sequencer.
package pll_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Default cycle constants for a 27 MHz reference
    localparam int DEF_RST_HOLD_CYCLES     = 32;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 270000;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CW                  = 19;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-high reset.
// o_q_next is the first-stage value, i.e. what o_q will show after the next
// edge; callers that need to anticipate an edge on o_q may use it, others
// leave it unconnected.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_q_next
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q      = r_sync;
    assign o_q_next = r_meta;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: pulses PLL reset, qualifies the synchronised
// LOCK for a stable period, retries on timeout and re-sequences on lock loss
// or request. All logic runs in the clkin domain; every output is registered
// from the next state so outputs always reflect the current state.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CW                  = DEF_CW
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       lock_i,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       user_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic       lock_lost
);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

    logic          w_lock_s;
    logic          w_lock_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_cnt_clr;
    logic          w_retry_inc;
    logic          w_retry_clr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_retry;
    logic          r_pll_reset;
    logic          r_user_rst;
    logic          r_ready;
    logic          r_fail;
    logic          r_lock_lost;

    sync_2ff u_lock_sync (
        .i_clk    (clkin),
        .i_rst    (rst),
        .i_d      (lock_i),
        .o_q      (w_lock_s),
        .o_q_next (w_lock_nxt)
    );

    // Next-state and counter/retry control; relock_req overrides every in-state move
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        if (relock_req) begin
            w_state_nxt = ST_HOLD;
            w_retry_clr = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) w_state_nxt = ST_WAIT;
                    else                    w_state_nxt = ST_HOLD;
                end
                ST_WAIT: begin
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        if (r_retry < RETRY_MAX) begin
                            w_state_nxt = ST_HOLD;
                            w_retry_inc = 1'b1;
                        end else begin
                            w_state_nxt = ST_FAIL;
                        end
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s)                 w_state_nxt = ST_WAIT;
                    else if (r_cnt == STABLE_LAST) w_state_nxt = ST_RUN;
                    else                           w_state_nxt = ST_STABLE;
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_HOLD;
                        w_retry_clr = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FAIL: w_state_nxt = ST_FAIL;
                default: w_state_nxt = ST_HOLD;
            endcase
        end
        w_cnt_clr = relock_req || (w_state_nxt != r_state);
    end

    // State, counter, retry count and registered Moore outputs
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_retry     <= 2'd0;
            r_pll_reset <= 1'b1;
            r_user_rst  <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr)             r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
            else                       r_cnt <= r_cnt;
            if (w_retry_clr)      r_retry <= 2'd0;
            else if (w_retry_inc) r_retry <= r_retry + 2'd1;
            else                  r_retry <= r_retry;
            r_pll_reset <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_FAIL);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_user_rst  <= (w_state_nxt != ST_RUN);
            r_fail      <= (w_state_nxt == ST_FAIL);
            // Flag the cycle in which lock_s drops while still in RUN
            r_lock_lost <= (w_state_nxt == ST_RUN) && w_lock_s && !w_lock_nxt;
        end
    end

    assign pll_reset = r_pll_reset;
    assign user_rst  = r_user_rst;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (HOLD=4, STABLE=8, TIMEOUT=20,
// MAX_RETRIES=2). Each table row holds inputs for n cycles; its expected
// outputs are queued when driven and compared after the last of those cycles.
module tb_pll_lock_sequencer;

    localparam int P_HOLD   = 4;
    localparam int P_STABLE = 8;
    localparam int P_TO     = 20;
    localparam int P_MAXR   = 2;
    localparam int P_CW     = 19;

    logic       clkin = 1'b0;
    logic       rst;
    logic       lock_i;
    logic       relock_req;
    logic       pll_reset;
    logic       user_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic       lock_lost;

    always #5 clkin = ~clkin;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (P_HOLD),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .MAX_RETRIES         (P_MAXR),
        .CW                  (P_CW)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .lock_i     (lock_i),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .user_rst   (user_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lock_lost  (lock_lost)
    );

    typedef struct {
        logic       rst;
        logic       lock;
        logic       relock;
        int         n;
        logic       pr;
        logic       ur;
        logic       rdy;
        logic       fl;
        logic [1:0] rc;
        logic       ll;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic l, input logic rq, input int n,
                       input logic pr, input logic ur, input logic rdy, input logic fl,
                       input logic [1:0] rc, input logic ll, input string nm);
        vec_t v;
        v.rst = r; v.lock = l; v.relock = rq; v.n = n;
        v.pr = pr; v.ur = ur; v.rdy = rdy; v.fl = fl; v.rc = rc; v.ll = ll;
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input string fld, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d at %0t", nm, fld, act, exp, $time);
        end
    endtask

    initial begin
        vec_t e;
        int   ll_count;
        bit   got_ready;

        rst        = 1'b1;
        lock_i     = 1'b0;
        relock_req = 1'b0;

        //   rst   lock  rq    n   pr    ur    rdy   fl    rc    ll
        add(1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "reset");
        add(1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "nom_hold");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "nom_hold_end");
        add(1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "nom_wait");
        add(1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "nom_pre_ready");
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "nom_ready");
        add(1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "nom_run");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "loss_pre");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, "loss_pulse");
        add(1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "loss_exit");
        add(1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "loss_hold");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "loss_wait");
        add(1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "to1_wait");
        add(1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "to1_hold");
        add(1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "to1_hold_end");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "to2_wait_start");
        add(1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "to2_wait");
        add(1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, "to2_hold");
        add(1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, "to2_hold_end");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, "to3_wait_start");
        add(1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, "to3_wait");
        add(1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, "fail_enter");
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, "fail_sticky");
        add(1'b0, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "relock_fail");
        add(1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "relock_hold");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "relock_wait");
        add(1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "unst_hi");
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "unst_lo");
        add(1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "unst_pre_ready");
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "unst_ready");
        add(1'b0, 1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "relock_run");
        add(1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "rr_hold");
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "rr_wait");
        add(1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "rr_pre_ready");
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "rr_ready");
        add(1'b0, 1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "relock_run2");
        add(1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s_hold");
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s_wait");
        add(1'b0, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s_stable");
        add(1'b1, 1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "rst_and_relock");
        add(1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "post_rst_hold");
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "post_rst_wait");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clkin);
            rst        = vecs[i].rst;
            lock_i     = vecs[i].lock;
            relock_req = vecs[i].relock;
            exp_q.push_back(vecs[i]);
            for (int k = 0; k < vecs[i].n; k++) begin
                @(posedge clkin);
            end
            #1;
            e = exp_q.pop_front();
            chk(e.name, "pll_reset", {1'b0, pll_reset}, {1'b0, e.pr});
            chk(e.name, "user_rst",  {1'b0, user_rst},  {1'b0, e.ur});
            chk(e.name, "ready",     {1'b0, ready},     {1'b0, e.rdy});
            chk(e.name, "fail",      {1'b0, fail},      {1'b0, e.fl});
            chk(e.name, "retry_cnt", retry_cnt,         e.rc);
            chk(e.name, "lock_lost", {1'b0, lock_lost}, {1'b0, e.ll});
        end

        // Hand sequence: reach RUN within a bounded budget, then drop lock and
        // require exactly one lock_lost pulse across the whole loss window.
        got_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clkin);
            #1;
            if (ready) begin
                got_ready = 1'b1;
                break;
            end
        end
        chk("hand_reach_run", "ready", {1'b0, ready}, 2'd1);
        if (got_ready) begin
            @(negedge clkin);
            lock_i   = 1'b0;
            ll_count = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clkin);
                #1;
                if (lock_lost) ll_count++;
            end
            chk("hand_loss", "lock_lost_pulses", 2'(ll_count), 2'd1);
            chk("hand_loss", "ready",            {1'b0, ready},    2'd0);
            chk("hand_loss", "user_rst",         {1'b0, user_rst}, 2'd1);
            chk("hand_loss", "retry_cnt",        retry_cnt,        2'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
